// File: rtl/arf_pkg.sv
// Shared types and default parameters for the arf_param address register file.
package arf_pkg;

  typedef enum logic [1:0] {
    ARF_CLR = 2'b00,
    ARF_LD  = 2'b01,
    ARF_INC = 2'b10,
    ARF_DEC = 2'b11
  } arf_fun_e;

  localparam int unsigned ARF_DEF_WIDTH    = 8;
  localparam int unsigned ARF_DEF_NREGS    = 4;
  localparam int unsigned ARF_DEF_SRC_IDX  = 3;
  localparam int unsigned ARF_DEF_HIST_IDX = 2;

endpackage

// File: rtl/arf_cell.sv
// One register of the address file: clear/load/inc/dec under enable, optional capture load,
// next-value output and a wrap strobe for explicit inc/dec only.
module arf_cell
  import arf_pkg::*;
#(
  parameter int unsigned WIDTH = ARF_DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  arf_fun_e         fun_i,
  input  logic [WIDTH-1:0] d_i,
  input  logic             cap_i,
  input  logic [WIDTH-1:0] cap_d_i,
  output logic [WIDTH-1:0] q_o,
  output logic [WIDTH-1:0] nxt_o,
  output logic             wrap_o
);

  localparam logic [WIDTH-1:0] One = WIDTH'(1);

  logic [WIDTH-1:0] val_q, val_d;

  // An explicit operation always takes priority over a capture load.
  always_comb begin
    val_d  = val_q;
    wrap_o = 1'b0;
    if (en_i) begin
      unique case (fun_i)
        ARF_CLR: val_d = '0;
        ARF_LD:  val_d = d_i;
        ARF_INC: begin
          val_d  = val_q + One;
          wrap_o = &val_q;
        end
        ARF_DEC: begin
          val_d  = val_q - One;
          wrap_o = ~|val_q;
        end
      endcase
    end else if (cap_i) begin
      val_d = cap_d_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      val_q <= '0;
    end else begin
      val_q <= val_d;
    end
  end

  assign q_o   = val_q;
  assign nxt_o = val_d;

endmodule

// File: rtl/arf_param.sv
// Parametrised address register file with two read ports, sticky wrap flags and PC history.
// Optional macro ARF_BYPASS_EN forwards next-state values to the read ports.
module arf_param
  import arf_pkg::*;
#(
  parameter int unsigned WIDTH    = ARF_DEF_WIDTH,
  parameter int unsigned NREGS    = ARF_DEF_NREGS,
  parameter int unsigned SRC_IDX  = ARF_DEF_SRC_IDX,
  parameter int unsigned HIST_IDX = ARF_DEF_HIST_IDX,
  parameter int unsigned SELW     = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i,
  input  logic [1:0]       funsel,
  input  logic [NREGS-1:0] r_sel,
  input  logic [SELW-1:0]  out_a_sel,
  input  logic [SELW-1:0]  out_b_sel,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic [NREGS-1:0] wrap,
  input  logic             wrap_clr
);

`ifdef ARF_BYPASS_EN
  localparam bit BypassEn = 1'b1;
`else
  localparam bit BypassEn = 1'b0;
`endif

  arf_fun_e         fun;
  logic             cap;
  logic [WIDTH-1:0] src_q, src_nxt;
  logic [WIDTH-1:0] rd_arr [NREGS];
  logic [NREGS-1:0] wrap_str, wrap_q, wrap_d;

  assign fun = arf_fun_e'(funsel);

  for (genvar k = 0; k < NREGS; k++) begin : g_cell
    logic [WIDTH-1:0] q, nxt;
    logic             wstr;

    arf_cell #(
      .WIDTH(WIDTH)
    ) u_cell (
      .clk    (clk),
      .rst    (rst),
      .en_i   (r_sel[k]),
      .fun_i  (fun),
      .d_i    (i),
      .cap_i  ((k == HIST_IDX) ? cap : 1'b0),
      .cap_d_i(src_q),
      .q_o    (q),
      .nxt_o  (nxt),
      .wrap_o (wstr)
    );

    assign rd_arr[k]   = (BypassEn && !rst) ? nxt : q;
    assign wrap_str[k] = wstr;
  end

  // Per-block signals keep the capture path free of a false loop through the history cell.
  assign src_q   = g_cell[SRC_IDX].q;
  assign src_nxt = g_cell[SRC_IDX].nxt;
  assign cap     = r_sel[SRC_IDX] & (src_nxt != src_q) & ~r_sel[HIST_IDX];

  // A new wrap beats a simultaneous clear.
  assign wrap_d = wrap_str | (wrap_q & {NREGS{~wrap_clr}});

  always_ff @(posedge clk) begin
    if (rst) begin
      wrap_q <= '0;
    end else begin
      wrap_q <= wrap_d;
    end
  end

  assign wrap = wrap_q;

  always_comb begin
    out_a = '0;
    out_b = '0;
    for (int k = 0; k < NREGS; k++) begin
      if (out_a_sel == SELW'(k)) out_a = rd_arr[k];
      if (out_b_sel == SELW'(k)) out_b = rd_arr[k];
    end
  end

endmodule

// File: tb/tb_arf_param.sv
// Self-checking bench for arf_param: default instance plus a 16-bit, 6-register instance.
module tb_arf_param;
  import arf_pkg::*;

  logic clk = 1'b0;
  logic rst;

  logic [7:0]  i0;  logic [1:0] fs0; logic [3:0] rs0; logic [1:0] sa0, sb0;
  logic [7:0]  oa0, ob0; logic [3:0] w0; logic wc0;
  logic [15:0] i1;  logic [1:0] fs1; logic [5:0] rs1; logic [2:0] sa1, sb1;
  logic [15:0] oa1, ob1; logic [5:0] w1; logic wc1;

  arf_param u_dut0 (
    .clk(clk), .rst(rst), .i(i0), .funsel(fs0), .r_sel(rs0), .out_a_sel(sa0),
    .out_b_sel(sb0), .out_a(oa0), .out_b(ob0), .wrap(w0), .wrap_clr(wc0)
  );

  arf_param #(.WIDTH(16), .NREGS(6)) u_dut1 (
    .clk(clk), .rst(rst), .i(i1), .funsel(fs1), .r_sel(rs1), .out_a_sel(sa1),
    .out_b_sel(sb1), .out_a(oa1), .out_b(ob1), .wrap(w1), .wrap_clr(wc1)
  );

  always #5 clk = ~clk;

  logic [15:0] m_reg  [2][16];
  logic [15:0] nx_reg [2][16];
  logic [15:0] m_wrap [2];
  logic [15:0] nx_wrap[2];
  int vecs = 0;
  int errs = 0;

  // Reference: next state of instance d from the current inputs, by the documented rules.
  task automatic calc(input int d);
    logic [15:0] iv, rs, mk, v, nw;
    logic [1:0]  f;
    logic        clr;
    int          n;
    if (d == 0) begin
      iv = 16'(i0); f = fs0; rs = 16'(rs0); clr = wc0; mk = 16'h00FF; n = 4;
    end else begin
      iv = i1; f = fs1; rs = 16'(rs1); clr = wc1; mk = 16'hFFFF; n = 6;
    end
    nw = '0;
    for (int k = 0; k < 16; k++) nx_reg[d][k] = m_reg[d][k];
    if (rst) begin
      for (int k = 0; k < 16; k++) nx_reg[d][k] = '0;
      nx_wrap[d] = '0;
    end else begin
      for (int k = 0; k < n; k++) begin
        if (rs[k]) begin
          v = m_reg[d][k];
          case (f)
            2'b00: nx_reg[d][k] = 16'h0;
            2'b01: nx_reg[d][k] = iv & mk;
            2'b10: begin nx_reg[d][k] = (v + 16'd1) & mk; nw[k] = (v == mk); end
            default: begin nx_reg[d][k] = (v - 16'd1) & mk; nw[k] = (v == 16'd0); end
          endcase
        end
      end
      if (rs[3] && !rs[2] && nx_reg[d][3] != m_reg[d][3]) nx_reg[d][2] = m_reg[d][3];
      nx_wrap[d] = nw | (clr ? 16'h0 : m_wrap[d]);
    end
  endtask

  task automatic tick();
    calc(0);
    calc(1);
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < 16; k++) m_reg[d][k] = nx_reg[d][k];
      m_wrap[d] = nx_wrap[d];
    end
    @(negedge clk);
  endtask

  task automatic settle();
    #1;
    calc(0);
    calc(1);
  endtask

  function automatic logic [15:0] exp_rd(input int d, input int sel);
    int n;
    n = (d == 0) ? 4 : 6;
    if (sel >= n) return 16'h0;
`ifdef ARF_BYPASS_EN
    if (!rst) return nx_reg[d][sel];
`endif
    return m_reg[d][sel];
  endfunction

  task automatic test_reset();
    rst = 1'b1; rs0 = 4'hF; fs0 = ARF_LD; i0 = 8'hAA; wc0 = 1'b0;
    rs1 = 6'h3F; fs1 = ARF_LD; i1 = 16'hAAAA; wc1 = 1'b0;
    tick();
    tick();
    for (int k = 0; k < 4; k++) begin
      sa0 = 2'(k); sb0 = 2'(3 - k);
      #1;
      vecs++;
      if (oa0 !== 8'h00 || ob0 !== 8'h00) begin
        errs++; $display("FAIL reset_rd%0d: got %h/%h want 00", k, oa0, ob0);
      end
    end
    vecs++;
    if (w0 !== 4'h0 || w1 !== 6'h0) begin
      errs++; $display("FAIL reset_wrap: got %h/%h want 0", w0, w1);
    end
    rst = 1'b0; rs0 = '0; rs1 = '0;
  endtask

  task automatic test_load_read();
    rs0 = 4'b0010; fs0 = ARF_LD; i0 = 8'h3C; sa0 = 2'd1; sb0 = 2'd1;
    tick();
    rs0 = '0;
    settle();
    vecs++;
    if (oa0 !== 8'h3C || ob0 !== 8'h3C) begin
      errs++; $display("FAIL load_rd: got %h/%h want 3c", oa0, ob0);
    end
    for (int k = 0; k < 4; k++) begin
      if (k != 1) begin
        sa0 = 2'(k);
        #1;
        vecs++;
        if (oa0 !== 8'h00) begin
          errs++; $display("FAIL load_other%0d: got %h want 00", k, oa0);
        end
      end
    end
  endtask

  task automatic test_inc_wrap();
    rs0 = 4'b0001; fs0 = ARF_LD; i0 = 8'hFF; sa0 = 2'd0;
    tick();
    fs0 = ARF_INC;
    tick();
    rs0 = '0;
    settle();
    vecs++;
    if (oa0 !== 8'h00 || w0 !== 4'b0001) begin
      errs++; $display("FAIL inc_wrap: got %h w=%b want 00 w=0001", oa0, w0);
    end
    rs0 = 4'b0001; fs0 = ARF_DEC; wc0 = 1'b1;
    tick();
    rs0 = '0; wc0 = 1'b0;
    settle();
    vecs++;
    if (oa0 !== 8'hFF || w0 !== 4'b0001) begin
      errs++; $display("FAIL dec_wrap_setwins: got %h w=%b want ff w=0001", oa0, w0);
    end
    wc0 = 1'b1;
    tick();
    wc0 = 1'b0;
    settle();
    vecs++;
    if (w0 !== 4'b0000) begin
      errs++; $display("FAIL wrap_clr: got %b want 0000", w0);
    end
  endtask

  task automatic test_history();
    sa0 = 2'd3; sb0 = 2'd2;
    rs0 = 4'b1000; fs0 = ARF_LD; i0 = 8'h10;
    tick();
    fs0 = ARF_INC;
    tick();
    rs0 = '0;
    settle();
    vecs++;
    if (oa0 !== 8'h11 || ob0 !== 8'h10) begin
      errs++; $display("FAIL hist_inc: got pc=%h past=%h want 11/10", oa0, ob0);
    end
    rs0 = 4'b1000; fs0 = ARF_CLR;
    tick();
    tick();
    rs0 = '0;
    settle();
    vecs++;
    if (oa0 !== 8'h00 || ob0 !== 8'h11) begin
      errs++; $display("FAIL hist_nochg: got pc=%h past=%h want 00/11", oa0, ob0);
    end
    rs0 = 4'b1100; fs0 = ARF_INC;
    tick();
    rs0 = '0;
    settle();
    vecs++;
    if (oa0 !== 8'h01 || ob0 !== 8'h12) begin
      errs++; $display("FAIL hist_explicit_inc: got pc=%h past=%h want 01/12", oa0, ob0);
    end
    rs0 = 4'b1100; fs0 = ARF_LD; i0 = 8'h77;
    tick();
    rs0 = '0;
    settle();
    vecs++;
    if (oa0 !== 8'h77 || ob0 !== 8'h77) begin
      errs++; $display("FAIL hist_explicit_ld: got pc=%h past=%h want 77/77", oa0, ob0);
    end
  endtask

  task automatic test_bypass();
    logic [7:0] want;
    rs0 = 4'b0100; fs0 = ARF_LD; i0 = 8'h5A; sa0 = 2'd2;
    settle();
`ifdef ARF_BYPASS_EN
    want = 8'h5A;
`else
    want = 8'h77;
`endif
    vecs++;
    if (oa0 !== want) begin
      errs++; $display("FAIL bypass_pre: got %h want %h", oa0, want);
    end
    tick();
    rs0 = '0;
    settle();
    vecs++;
    if (oa0 !== 8'h5A) begin
      errs++; $display("FAIL bypass_post: got %h want 5a", oa0);
    end
  endtask

  task automatic test_param();
    sa1 = 3'd7; sb1 = 3'd6;
    settle();
    vecs++;
    if (oa1 !== 16'h0 || ob1 !== 16'h0) begin
      errs++; $display("FAIL param_oob: got %h/%h want 0000", oa1, ob1);
    end
    rs1 = 6'b100000; fs1 = ARF_DEC; sa1 = 3'd5;
    tick();
    rs1 = '0;
    settle();
    vecs++;
    if (oa1 !== 16'hFFFF || w1 !== 6'b100000) begin
      errs++; $display("FAIL param_dec_wrap: got %h w=%b want ffff w=100000", oa1, w1);
    end
  endtask

  task automatic test_random();
    logic [15:0] e0a, e0b, e1a, e1b;
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(31) == 0);
      case ($urandom_range(3))
        0: i0 = 8'h00;
        1: i0 = 8'hFF;
        default: i0 = 8'($urandom);
      endcase
      i1 = ($urandom_range(3) == 0) ? 16'hFFFF : 16'($urandom);
      fs0 = 2'($urandom); rs0 = 4'($urandom); sa0 = 2'($urandom); sb0 = 2'($urandom);
      fs1 = 2'($urandom); rs1 = 6'($urandom); sa1 = 3'($urandom); sb1 = 3'($urandom);
      wc0 = ($urandom_range(7) == 0);
      wc1 = ($urandom_range(7) == 0);
      settle();
      e0a = exp_rd(0, int'(sa0)); e0b = exp_rd(0, int'(sb0));
      e1a = exp_rd(1, int'(sa1)); e1b = exp_rd(1, int'(sb1));
      vecs++;
      if (oa0 !== e0a[7:0] || ob0 !== e0b[7:0] || w0 !== m_wrap[0][3:0]) begin
        errs++;
        $display("FAIL rand0 #%0d: got a=%h b=%h w=%b want a=%h b=%h w=%b", n, oa0, ob0, w0,
                 e0a[7:0], e0b[7:0], m_wrap[0][3:0]);
      end
      vecs++;
      if (oa1 !== e1a || ob1 !== e1b || w1 !== m_wrap[1][5:0]) begin
        errs++;
        $display("FAIL rand1 #%0d: got a=%h b=%h w=%b want a=%h b=%h w=%b", n, oa1, ob1, w1,
                 e1a, e1b, m_wrap[1][5:0]);
      end
      tick();
    end
    rst = 1'b0; rs0 = '0; rs1 = '0; wc0 = 1'b0; wc1 = 1'b0;
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < 16; k++) m_reg[d][k] = '0;
      m_wrap[d] = '0;
    end
    rst = 1'b1;
    i0 = '0; fs0 = '0; rs0 = '0; sa0 = '0; sb0 = '0; wc0 = 1'b0;
    i1 = '0; fs1 = '0; rs1 = '0; sa1 = '0; sb1 = '0; wc1 = 1'b0;
    @(negedge clk);
    test_reset();
    test_load_read();
    test_inc_wrap();
    test_history();
    test_bypass();
    test_param();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
